// File: rtl/dnn_pkg.sv
// Shared state encoding and default geometry for the DNN frame I/O block.
package dnn_pkg;

  localparam int COLS_DEF   = 784;
  localparam int ROWS_DEF   = 10;
  localparam int PIX_W_DEF  = 8;
  localparam int IN_W_DEF   = 9;
  localparam int OUT_W_DEF  = 9;
  localparam int SETTLE_DEF = 4;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_SCAN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/dnn_argmax_scan.sv
// Sequential argmax: one element per cycle, strict greater-than so ties keep the lowest index.
module dnn_argmax_scan import dnn_pkg::*; #(
  parameter int ROWS  = ROWS_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic signed [OUT_W-1:0]    elem,
  output logic [$clog2(ROWS)-1:0]    sel,
  output logic [$clog2(ROWS)-1:0]    best_idx,
  output logic signed [OUT_W-1:0]    best_score,
  output logic                       done
);

  localparam int IW = $clog2(ROWS);

  logic          busy;
  logic [IW-1:0] cnt;

  assign sel  = cnt;
  // done marks the cycle in which the last element is being compared
  assign done = busy && (cnt == IW'(ROWS - 1));

  // walk the snapshot; element 0 always seeds the running best
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      cnt        <= '0;
      best_idx   <= '0;
      best_score <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == '0 || elem > best_score) begin
        best_score <= elem;
        best_idx   <= cnt;
      end
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dnn_frame_io.sv
// Frame loader / result picker wrapped around a combinational classifier network.
module dnn_frame_io import dnn_pkg::*; #(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_pix_valid,
  output logic                          s_pix_ready,
  input  logic [PIX_W-1:0]              s_pix_data,
  input  logic                          s_pix_last,
  output logic [COLS-1:0][IN_W-1:0]     input_vector,
  input  logic [ROWS-1:0][OUT_W-1:0]    output_vector,
  output logic                          m_res_valid,
  input  logic                          m_res_ready,
  output logic [$clog2(ROWS)-1:0]       m_res_class,
  output logic signed [OUT_W-1:0]       m_res_score,
  output logic                          frame_err
);

  localparam int XW = $clog2(COLS);
  localparam int IW = $clog2(ROWS);

  state_t                     state, state_nx;
  logic [XW-1:0]              idx;
  logic [7:0]                 scnt;
  logic [ROWS-1:0][OUT_W-1:0] snap;
  logic [IW-1:0]              sel;
  logic signed [OUT_W-1:0]    elem;
  logic                       hs, at_end, settle_done, scan_start, scan_done;

  assign hs          = s_pix_valid & s_pix_ready;
  assign at_end      = (idx == XW'(COLS - 1));
  assign settle_done = (state == ST_SETTLE) && (scnt == 8'(SETTLE - 1));
  assign elem        = snap[sel];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nx;
  end

  // next-state and scan kick-off
  always_comb begin
    state_nx   = state;
    scan_start = 1'b0;
    case (state)
      ST_LOAD:   if (hs && at_end) state_nx = ST_SETTLE;
      ST_SETTLE: begin
        scan_start = settle_done;
        if (settle_done) state_nx = ST_SCAN;
      end
      ST_SCAN:   if (scan_done) state_nx = ST_HOLD;
      ST_HOLD:   if (m_res_ready) state_nx = ST_LOAD;
      default:   state_nx = ST_LOAD;
    endcase
  end

  // pixel capture, framing check, settle timer, snapshot and result-valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      input_vector <= '0;
      frame_err    <= 1'b0;
      s_pix_ready  <= 1'b0;
      scnt         <= '0;
      snap         <= '0;
      m_res_valid  <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      // registered so ready only appears one edge after reset release
      s_pix_ready <= (state_nx == ST_LOAD);
      if (hs) begin
        input_vector[idx] <= IN_W'(s_pix_data);
        frame_err         <= at_end ? !s_pix_last : s_pix_last;
        idx               <= (at_end || s_pix_last) ? '0 : idx + 1'b1;
      end
      scnt <= (state == ST_SETTLE) ? scnt + 1'b1 : 8'd0;
      if (scan_start) snap <= output_vector;
      if (scan_done)                            m_res_valid <= 1'b1;
      else if (state == ST_HOLD && m_res_ready) m_res_valid <= 1'b0;
    end
  end

  dnn_argmax_scan #(.ROWS(ROWS), .OUT_W(OUT_W)) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (scan_start),
    .elem       (elem),
    .sel        (sel),
    .best_idx   (m_res_class),
    .best_score (m_res_score),
    .done       (scan_done)
  );

endmodule

// File: tb/tb_dnn_frame_io.sv
// Randomized frame-level bench with a behavioural argmax / vector model.
module tb_dnn_frame_io;

  localparam int COLS = 784, ROWS = 10, PIX_W = 8, IN_W = 9, OUT_W = 9, SETTLE = 4;
  localparam int CW = $clog2(ROWS);

  logic                       clk = 1'b0, rst_n = 1'b0;
  logic                       s_pix_valid, s_pix_ready, s_pix_last;
  logic [PIX_W-1:0]           s_pix_data;
  logic [COLS-1:0][IN_W-1:0]  input_vector;
  logic [ROWS-1:0][OUT_W-1:0] output_vector;
  logic                       m_res_valid, m_res_ready, frame_err;
  logic [CW-1:0]              m_res_class;
  logic signed [OUT_W-1:0]    m_res_score;

  int exp_iv[COLS];
  int pix[COLS];
  int sc[ROWS];
  int npass = 0, ntot = 0, cyc = 0, err_cnt = 0, err_exp = 0, e0 = 0;
  bit abort = 0;

  dnn_frame_io #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .IN_W(IN_W),
                 .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .s_pix_data(s_pix_data), .s_pix_last(s_pix_last),
    .input_vector(input_vector), .output_vector(output_vector),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
    .m_res_class(m_res_class), .m_res_score(m_res_score),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int iv_bad();
    int n = 0;
    for (int i = 0; i < COLS; i++)
      if (int'($signed(input_vector[i])) != exp_iv[i]) n++;
    return n;
  endfunction

  task automatic scramble();
    for (int r = 0; r < ROWS; r++) output_vector[r] = OUT_W'($urandom);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < COLS; i++) pix[i] = int'($urandom_range(0, 255));
    for (int r = 0; r < ROWS; r++) sc[r] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic push(input int p, input bit l);
    int n;
    n = 0;
    if (abort) return;
    @(negedge clk);
    s_pix_valid = 1'b1; s_pix_data = PIX_W'(p); s_pix_last = l;
    while (!s_pix_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_pix_ready) begin
      chk("pix_ready_timeout", 0, 1);
      abort = 1; s_pix_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e0 = cyc;
    s_pix_valid = 1'b0;
  endtask

  // stream a frame; real scores only visible from the final pixel to the snapshot edge
  task automatic load_frame(input bit no_last);
    scramble();
    for (int i = 0; i < COLS; i++) begin
      push(pix[i], (i == COLS - 1) && !no_last);
      exp_iv[i] = pix[i];
    end
    for (int r = 0; r < ROWS; r++) output_vector[r] = OUT_W'(sc[r]);
    s_pix_valid = 1'b1; s_pix_data = 8'hA5; s_pix_last = 1'b1;
    repeat (SETTLE) @(posedge clk);
    #1 scramble();
  endtask

  task automatic get_result(input int hold);
    int n, best, bad;
    logic [CW-1:0] c0;
    logic signed [OUT_W-1:0] s0;
    n = 0; bad = 0; best = 0;
    for (int r = 1; r < ROWS; r++) if (sc[r] > sc[best]) best = r;
    @(negedge clk);
    while (!m_res_valid && n < 100) begin @(negedge clk); n++; end
    s_pix_valid = 1'b0;
    chk("res_valid", m_res_valid, 1);
    chk("latency", cyc - e0, SETTLE + ROWS);
    chk("class", m_res_class, best);
    chk("score", m_res_score, sc[best]);
    chk("frame_err_cnt", err_cnt, err_exp);
    chk("input_vector", iv_bad(), 0);
    if (hold > 0) begin
      c0 = m_res_class; s0 = m_res_score;
      repeat (hold) begin
        @(negedge clk);
        if (!m_res_valid || m_res_class != c0 || m_res_score != s0 || s_pix_ready) bad++;
      end
      chk("hold_stable", bad, 0);
      m_res_ready = 1'b1;
    end
    @(negedge clk);
    chk("valid_drop", m_res_valid, 0);
    chk("ready_back", s_pix_ready, 1);
  endtask

  initial begin
    s_pix_valid = 1'b0; s_pix_data = '0; s_pix_last = 1'b0;
    m_res_ready = 1'b1; output_vector = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", s_pix_ready, 0);
    chk("rst_valid", m_res_valid, 0);
    chk("rst_class", m_res_class, 0);
    chk("rst_score", m_res_score, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_iv", iv_bad(), 0);
    rst_n = 1'b1;
    #1 chk("ready_pre_edge", s_pix_ready, 0);
    @(negedge clk);
    chk("ready_post_edge", s_pix_ready, 1);

    // all-255 frame, ties at 2/3, ready held high
    for (int i = 0; i < COLS; i++) pix[i] = 255;
    sc = '{-5, 3, 7, 7, 0, -1, -2, -3, -4, -6};
    load_frame(0);
    get_result(0);

    // random frame, consumer stalls 20 cycles
    rand_frame();
    m_res_ready = 1'b0;
    load_frame(0);
    get_result(20);

    // early last on pixel index 100, then a full frame with a forced tie
    for (int i = 0; i <= 100; i++) begin
      pix[i] = int'($urandom_range(0, 255));
      push(pix[i], i == 100);
      exp_iv[i] = pix[i];
    end
    err_exp++;
    @(negedge clk); #1;
    chk("short_err", err_cnt, err_exp);
    chk("short_ready", s_pix_ready, 1);
    chk("short_retain", iv_bad(), 0);
    rand_frame();
    sc[3] = 255; sc[7] = 255;
    load_frame(0);
    get_result(0);

    // full frame without last
    rand_frame();
    load_frame(1);
    err_exp++;
    get_result(0);

    // all negative scores, winner in the last slot
    rand_frame();
    for (int r = 0; r < ROWS; r++) sc[r] = int'($urandom_range(0, 100)) - 256;
    sc[ROWS-1] = -1;
    load_frame(0);
    get_result(0);

    for (int k = 0; k < 3; k++) begin
      rand_frame();
      load_frame(0);
      get_result(0);
    end

    // reset while scanning
    rand_frame();
    load_frame(0);
    @(posedge clk); #1;
    s_pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < COLS; i++) exp_iv[i] = 0;
    chk("mid_rst_valid", m_res_valid, 0);
    chk("mid_rst_ready", s_pix_ready, 0);
    chk("mid_rst_class", m_res_class, 0);
    chk("mid_rst_score", m_res_score, 0);
    chk("mid_rst_iv", iv_bad(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_up", s_pix_ready, 1);
    begin
      int seen;
      seen = 0;
      repeat (30) begin @(negedge clk); if (m_res_valid) seen++; end
      chk("mid_rst_no_valid", seen, 0);
    end
    chk("mid_rst_err", err_cnt, err_exp);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
